// File: rtl/sd_init_sequencer.sv
// SD card init sequencer: CMD0/8/55+41/2/3/7 chain to transfer state, feeding cmd_driver.
// Define SD_WIDE_BUS_EN to append CMD55/ACMD6 (4-bit bus select) after CMD7.
module sd_init_sequencer #(
  parameter int ACMD41_TRIES = 1000,
  parameter int CRC_RETRIES  = 3
) (
  input  logic         iclk,
  input  logic         irst,
  input  logic         istart,
  output logic         ocmd_send,
  output logic [6:0]   ocmd_index,
  output logic [31:0]  ocmd_arg,
  input  logic [0:135] iresp,
  input  logic         icrc_failed,
  input  logic         icmd_done,
  output logic         oready,
  output logic         oerr,
  output logic [2:0]   oerr_code,
  output logic [15:0]  orca,
  output logic         ohcs
);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD0, S_CMD8, S_CMD55, S_ACMD41, S_CMD2, S_CMD3, S_CMD7,
    S_CMD55W, S_ACMD6, S_READY, S_ERROR
  } state_t;

  localparam int RW = $clog2(ACMD41_TRIES + 1);
  localparam int CW = (CRC_RETRIES > 0) ? $clog2(CRC_RETRIES + 1) : 1;
  localparam logic [RW-1:0] ROUND_MAX = RW'(ACMD41_TRIES);
  localparam logic [CW-1:0] CRC_MAX   = CW'(CRC_RETRIES);

  localparam logic [2:0] ERR_CRC   = 3'd1;
  localparam logic [2:0] ERR_ECHO  = 3'd2;
  localparam logic [2:0] ERR_ACMD  = 3'd3;

  state_t        state_q, state_d;
  logic          issue_q, issue_d;
  logic [RW-1:0] round_q, round_d;
  logic [CW-1:0] crc_q, crc_d;
  logic [15:0]   rca_q, rca_d;
  logic          hcs_q, hcs_d;
  logic [2:0]    code_q, code_d;
  logic          crc_checked;
  logic          unused_resp;

  // Start bit, index, CMD8 reserved/VHS bits, CRC and the R2 tail are not interpreted here.
  assign unused_resp = ^{iresp[0:7], iresp[24:27], iresp[40:135]};

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q <= S_IDLE;
      issue_q <= 1'b0;
      round_q <= '0;
      crc_q   <= '0;
      rca_q   <= '0;
      hcs_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      round_q <= round_d;
      crc_q   <= crc_d;
      rca_q   <= rca_d;
      hcs_q   <= hcs_d;
      code_q  <= code_d;
    end
  end

  // R3 carries no valid CRC, and CMD0 has no response to check.
  assign crc_checked = (state_q != S_CMD0) && (state_q != S_ACMD41);

  always_comb begin
    state_d = state_q;
    issue_d = 1'b0;
    round_d = round_q;
    crc_d   = crc_q;
    rca_d   = rca_q;
    hcs_d   = hcs_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE, S_READY, S_ERROR: begin
        if (istart) begin
          state_d = S_CMD0;
          issue_d = 1'b1;
          round_d = '0;
          crc_d   = '0;
          rca_d   = '0;
          hcs_d   = 1'b0;
          code_d  = '0;
        end
      end
      default: begin
        if (!issue_q && icmd_done) begin
          if (crc_checked && icrc_failed) begin
            if (crc_q == CRC_MAX) begin
              state_d = S_ERROR;
              code_d  = ERR_CRC;
            end else begin
              crc_d   = crc_q + CW'(1);
              issue_d = 1'b1;
            end
          end else begin
            crc_d   = '0;
            issue_d = 1'b1;
            case (state_q)
              S_CMD0:  state_d = S_CMD8;
              S_CMD8: begin
                if (iresp[28:39] == 12'h1AA) begin
                  state_d = S_CMD55;
                end else begin
                  state_d = S_ERROR;
                  code_d  = ERR_ECHO;
                  issue_d = 1'b0;
                end
              end
              S_CMD55: state_d = S_ACMD41;
              S_ACMD41: begin
                if (iresp[8]) begin
                  hcs_d   = iresp[9];
                  state_d = S_CMD2;
                end else if (round_q + RW'(1) == ROUND_MAX) begin
                  round_d = round_q + RW'(1);
                  state_d = S_ERROR;
                  code_d  = ERR_ACMD;
                  issue_d = 1'b0;
                end else begin
                  round_d = round_q + RW'(1);
                  state_d = S_CMD55;
                end
              end
              S_CMD2:  state_d = S_CMD3;
              S_CMD3: begin
                rca_d   = iresp[8:23];
                state_d = S_CMD7;
              end
              S_CMD7: begin
`ifdef SD_WIDE_BUS_EN
                state_d = S_CMD55W;
`else
                state_d = S_READY;
                issue_d = 1'b0;
`endif
              end
              S_CMD55W: state_d = S_ACMD6;
              S_ACMD6: begin
                state_d = S_READY;
                issue_d = 1'b0;
              end
              default: begin
                state_d = state_q;
                issue_d = 1'b0;
              end
            endcase
          end
        end
      end
    endcase
  end

  always_comb begin
    ocmd_index = 7'd0;
    ocmd_arg   = 32'h0;
    case (state_q)
      S_CMD8: begin
        ocmd_index = 7'd8;
        ocmd_arg   = 32'h0000_01AA;
      end
      S_CMD55, S_CMD55W: begin
        ocmd_index = 7'd55;
        ocmd_arg   = {rca_q, 16'h0};
      end
      S_ACMD41: begin
        ocmd_index = 7'd41;
        ocmd_arg   = 32'h40FF_8000;
      end
      S_CMD2: ocmd_index = 7'd2;
      S_CMD3: ocmd_index = 7'd3;
      S_CMD7: begin
        ocmd_index = 7'd7;
        ocmd_arg   = {rca_q, 16'h0};
      end
      S_ACMD6: begin
        ocmd_index = 7'd6;
        ocmd_arg   = 32'h0000_0002;
      end
      default: begin
        ocmd_index = 7'd0;
        ocmd_arg   = 32'h0;
      end
    endcase
  end

  assign ocmd_send = issue_q;
  assign oready    = (state_q == S_READY);
  assign oerr      = (state_q == S_ERROR);
  assign oerr_code = code_q;
  assign orca      = rca_q;
  assign ohcs      = hcs_q;

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Randomized bench for sd_init_sequencer: a card responder plus a command-list reference model.
module tb_sd_init_sequencer;
  localparam int TRIES   = 4;
  localparam int RETRIES = 3;

  logic         iclk = 1'b0;
  logic         irst, istart, ocmd_send, icrc_failed, icmd_done;
  logic         oready, oerr, ohcs;
  logic [6:0]   ocmd_index;
  logic [31:0]  ocmd_arg;
  logic [0:135] iresp;
  logic [2:0]   oerr_code;
  logic [15:0]  orca;

  int checks   = 0;
  int failures = 0;

  always #5 iclk = ~iclk;

  sd_init_sequencer #(.ACMD41_TRIES(TRIES), .CRC_RETRIES(RETRIES)) dut (
    .iclk(iclk), .irst(irst), .istart(istart),
    .ocmd_send(ocmd_send), .ocmd_index(ocmd_index), .ocmd_arg(ocmd_arg),
    .iresp(iresp), .icrc_failed(icrc_failed), .icmd_done(icmd_done),
    .oready(oready), .oerr(oerr), .oerr_code(oerr_code), .orca(orca), .ohcs(ohcs)
  );

  // Card behaviour for the current scenario
  int          cfg_ack_round;   // ACMD41 round that reports power-up done, 0 = never
  logic        cfg_hcs;
  logic [15:0] cfg_rca;
  logic [11:0] cfg_echo;
  int          cfg_crc_cmd;     // command whose first issues fail CRC, -1 = none
  int          cfg_crc_fails;
  bit          cfg_poke;        // inject ignored istart / stray icmd_done

  int          obs_idx[$];
  logic [31:0] obs_arg[$];
  int          exp_idx[$];
  logic [31:0] exp_arg[$];
  logic        exp_ready, exp_err, exp_hcs;
  logic [2:0]  exp_code;
  logic [15:0] exp_rca;

  task automatic model_cmd(input int idx, input logic [31:0] arg, output bit dead);
    int issues;
    issues = 1;
    if (idx == cfg_crc_cmd)
      issues = (cfg_crc_fails > RETRIES) ? RETRIES + 1 : cfg_crc_fails + 1;
    for (int i = 0; i < issues; i++) begin
      exp_idx.push_back(idx);
      exp_arg.push_back(arg);
    end
    dead = (idx == cfg_crc_cmd) && (cfg_crc_fails > RETRIES);
  endtask

  task automatic build_model();
    bit dead;
    int rounds;
    exp_idx.delete();
    exp_arg.delete();
    exp_ready = 1'b0; exp_err = 1'b1; exp_code = 3'd0; exp_rca = 16'h0; exp_hcs = 1'b0;
    model_cmd(0, 32'h0, dead);
    model_cmd(8, 32'h1AA, dead);
    if (dead) begin exp_code = 3'd1; return; end
    if (cfg_echo != 12'h1AA) begin exp_code = 3'd2; return; end
    rounds = (cfg_ack_round == 0) ? TRIES : cfg_ack_round;
    for (int r = 0; r < rounds; r++) begin
      model_cmd(55, 32'h0, dead);
      model_cmd(41, 32'h40FF8000, dead);
    end
    if (cfg_ack_round == 0) begin exp_code = 3'd3; return; end
    exp_hcs = cfg_hcs;
    model_cmd(2, 32'h0, dead);
    if (dead) begin exp_code = 3'd1; return; end
    model_cmd(3, 32'h0, dead);
    if (dead) begin exp_code = 3'd1; return; end
    exp_rca = cfg_rca;
    model_cmd(7, {cfg_rca, 16'h0}, dead);
    if (dead) begin exp_code = 3'd1; return; end
`ifdef SD_WIDE_BUS_EN
    model_cmd(55, {cfg_rca, 16'h0}, dead);
    model_cmd(6, 32'h2, dead);
`endif
    exp_err = 1'b0;
    exp_ready = 1'b1;
  endtask

  task automatic start_seq(input string name);
    @(negedge iclk);
    istart = 1'b1;
    @(negedge iclk);
    istart = 1'b0;
    checks++;
    if (!(ocmd_send === 1'b1 && ocmd_index === 7'd0 && oready === 1'b0 && oerr === 1'b0 &&
          oerr_code === 3'd0 && orca === 16'h0 && ohcs === 1'b0)) begin
      failures++;
      $display("FAIL %s start: send=%b idx=%0d rdy=%b err=%b code=%0d rca=%h hcs=%b, required send=1 idx=0 status cleared",
               name, ocmd_send, ocmd_index, oready, oerr, oerr_code, orca, ohcs);
    end
  endtask

  // Plays the card from the current negedge until ready/error, a stop command, or budget.
  task automatic run_card(input string name, input int budget, input int stop_idx, output bit ok);
    int pend, cur, n41, nfail;
    logic [31:0] cur_arg;
    bit prev_send, expect_send, poke;
    pend = 0; cur = -1; cur_arg = 32'h0; n41 = 0; nfail = 0;
    prev_send = 1'b0; expect_send = 1'b0; poke = cfg_poke; ok = 1'b0;
    obs_idx.delete();
    obs_arg.delete();
    for (int c = 0; c < budget; c++) begin
      icmd_done = 1'b0; icrc_failed = 1'b0; istart = 1'b0;
      if (expect_send) begin
        expect_send = 1'b0;
        checks++;
        if (ocmd_send !== 1'b1 && oready !== 1'b1 && oerr !== 1'b1) begin
          failures++;
          $display("FAIL %s next_issue: send=%b rdy=%b err=%b one cycle after done, required send or terminal",
                   name, ocmd_send, oready, oerr);
        end
      end
      if (oready === 1'b1 || oerr === 1'b1) begin ok = 1'b1; break; end
      if (ocmd_send === 1'b1) begin
        if (int'(ocmd_index) == stop_idx) begin ok = 1'b1; break; end
        checks++;
        if (prev_send) begin
          failures++;
          $display("FAIL %s send_gap: ocmd_send high on consecutive cycles", name);
        end
        obs_idx.push_back(int'(ocmd_index));
        obs_arg.push_back(ocmd_arg);
        cur = int'(ocmd_index); cur_arg = ocmd_arg;
        pend = $urandom_range(1, 3);
        prev_send = 1'b1;
        if (poke && $urandom_range(0, 1) == 1) begin
          iresp = {$urandom(), $urandom(), $urandom(), $urandom(), 8'($urandom())};
          icrc_failed = 1'b1;
          icmd_done = 1'b1;
        end
      end else begin
        prev_send = 1'b0;
        if (pend > 0) begin
          checks++;
          if (int'(ocmd_index) != cur || ocmd_arg !== cur_arg) begin
            failures++;
            $display("FAIL %s wait_hold: idx=%0d arg=%h, required idx=%0d arg=%h",
                     name, ocmd_index, ocmd_arg, cur, cur_arg);
          end
          pend--;
          if (pend == 0) begin
            iresp = {$urandom(), $urandom(), $urandom(), $urandom(), 8'($urandom())};
            case (cur)
              0: icrc_failed = 1'($urandom_range(0, 1));
              8: iresp[28:39] = cfg_echo;
              41: begin
                n41++;
                iresp[8] = (n41 == cfg_ack_round);
                iresp[9] = cfg_hcs;
                icrc_failed = 1'($urandom_range(0, 1));
              end
              3: iresp[8:23] = cfg_rca;
              default: ;
            endcase
            if (cur == cfg_crc_cmd && nfail < cfg_crc_fails) begin
              icrc_failed = 1'b1;
              nfail++;
            end
            icmd_done = 1'b1;
            expect_send = 1'b1;
          end else if (poke && $urandom_range(0, 3) == 0) begin
            istart = 1'b1;
            poke = 1'b0;
          end
        end
      end
      @(negedge iclk);
    end
    icmd_done = 1'b0; icrc_failed = 1'b0; istart = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s timeout: no ready/error within %0d cycles", name, budget);
    end
  endtask

  task automatic check_result(input string name);
    int n, extra;
    checks++;
    if (obs_idx.size() != exp_idx.size()) begin
      failures++;
      $display("FAIL %s cmd_count: got %0d required %0d", name, obs_idx.size(), exp_idx.size());
    end
    n = (obs_idx.size() < exp_idx.size()) ? obs_idx.size() : exp_idx.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_idx[i] != exp_idx[i] || obs_arg[i] !== exp_arg[i]) begin
        failures++;
        $display("FAIL %s cmd[%0d]: got %0d/%h required %0d/%h",
                 name, i, obs_idx[i], obs_arg[i], exp_idx[i], exp_arg[i]);
      end
    end
    checks++;
    if ({oready, oerr, oerr_code} !== {exp_ready, exp_err, exp_code}) begin
      failures++;
      $display("FAIL %s status: rdy=%b err=%b code=%0d required rdy=%b err=%b code=%0d",
               name, oready, oerr, oerr_code, exp_ready, exp_err, exp_code);
    end
    checks++;
    if (orca !== exp_rca || ohcs !== exp_hcs) begin
      failures++;
      $display("FAIL %s card_id: rca=%h hcs=%b required rca=%h hcs=%b", name, orca, ohcs, exp_rca, exp_hcs);
    end
    extra = 0;
    repeat (4) begin
      @(negedge iclk);
      if (ocmd_send !== 1'b0 || oready !== exp_ready || oerr !== exp_err) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL %s quiet: %0d cycles with a send or status change after the end, required 0", name, extra);
    end
  endtask

  task automatic run_scenario(input string name);
    bit ok;
    build_model();
    start_seq(name);
    run_card(name, 600, -1, ok);
    check_result(name);
  endtask

  task automatic set_nominal();
    cfg_ack_round = 3; cfg_hcs = 1'b1; cfg_rca = 16'hB368; cfg_echo = 12'h1AA;
    cfg_crc_cmd = -1; cfg_crc_fails = 0; cfg_poke = 1'b0;
  endtask

  task automatic test_reset();
    irst = 1'b1; istart = 1'b0; icmd_done = 1'b0; icrc_failed = 1'b0; iresp = '0;
    repeat (3) @(negedge iclk);
    checks++;
    if ({ocmd_send, ocmd_index, ocmd_arg, oready, oerr, oerr_code, orca, ohcs} !== '0) begin
      failures++;
      $display("FAIL reset: send=%b idx=%0d arg=%h rdy=%b err=%b code=%0d rca=%h hcs=%b, required all 0",
               ocmd_send, ocmd_index, ocmd_arg, oready, oerr, oerr_code, orca, ohcs);
    end
    irst = 1'b0;
  endtask

  task automatic test_nominal();
    set_nominal();
    run_scenario("nominal");
  endtask

  task automatic test_cmd8_mismatch();
    set_nominal();
    cfg_echo = 12'h0AA;
    run_scenario("cmd8_echo");
  endtask

  task automatic test_acmd41_timeout();
    set_nominal();
    cfg_ack_round = 0;
    run_scenario("acmd41_timeout");
  endtask

  task automatic test_crc_retry();
    set_nominal();
    cfg_crc_cmd = 2; cfg_crc_fails = 2;
    run_scenario("crc_retry_ok");
    cfg_crc_fails = 4;
    run_scenario("crc_retry_exhaust");
  endtask

  task automatic test_irst_midflight();
    bit ok;
    int stops[2] = '{3, 2};
    foreach (stops[k]) begin
      set_nominal();
      start_seq("irst");
      run_card("irst", 600, stops[k], ok);
      if (k == 0) @(negedge iclk);  // sit in the CMD3 WAIT phase
      #2 irst = 1'b1;
      #1;
      checks++;
      if ({ocmd_send, ocmd_index, ocmd_arg, oready, oerr, oerr_code, orca, ohcs} !== '0) begin
        failures++;
        $display("FAIL irst_async(stop %0d): send=%b idx=%0d rdy=%b err=%b rca=%h hcs=%b, required all 0",
                 stops[k], ocmd_send, ocmd_index, oready, oerr, orca, ohcs);
      end
      @(negedge iclk);
      irst = 1'b0;
      run_scenario("irst_restart");
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      cfg_ack_round = $urandom_range(0, TRIES);
      cfg_hcs       = 1'($urandom_range(0, 1));
      cfg_rca       = 16'($urandom());
      cfg_echo      = ($urandom_range(0, 7) == 0) ? 12'($urandom()) : 12'h1AA;
      case ($urandom_range(0, 4))
        0: cfg_crc_cmd = -1;
        1: cfg_crc_cmd = 8;
        2: cfg_crc_cmd = 2;
        3: cfg_crc_cmd = 3;
        default: cfg_crc_cmd = 7;
      endcase
      cfg_crc_fails = $urandom_range(0, 5);
      cfg_poke      = 1'($urandom_range(0, 1));
      run_scenario($sformatf("random%0d", n));
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_cmd8_mismatch();
    test_acmd41_timeout();
    test_crc_retry();
    test_irst_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_init_sequencer.md
# sd_init_sequencer

Command-level sequencer that brings an SD card from power-up to the transfer state and feeds `cmd_driver` directly. It issues the SD initialization command chain (CMD0, CMD8, CMD55/ACMD41 polling, CMD2, CMD3, CMD7), parses the responses, and captures the card's RCA and capacity class. It raises ready or a coded error to the top-level controller. It owns only command ordering and response interpretation; bit-level CMD line serialization and CRC7 stay in `cmd_driver`.

## Interface
- `ACMD41_TRIES`, default 1000: maximum CMD55/ACMD41 polling rounds before a timeout error.
- `CRC_RETRIES`, default 3: re-issues of a single command after a CRC failure.
- `iclk` input 1: system clock.
- `irst` input 1: global reset, asynchronous, active-high.
- `istart` input 1: single-cycle pulse that starts the sequence.
- `ocmd_send` output 1: single-cycle pulse to `cmd_driver` `isend`.
- `ocmd_index` output 7: command index to `cmd_driver` `icmd_index`.
- `ocmd_arg` output 32: command argument to `cmd_driver` `icmd_arg`.
- `iresp` input [0:135]: response from `cmd_driver` `oresp`.
- `icrc_failed` input 1: response CRC failure flag from `cmd_driver`.
- `icmd_done` input 1: operation-done pulse from `cmd_driver`.
- `oready` output 1: card is in the transfer state.
- `oerr` output 1: sequence aborted.
- `oerr_code` output 3: error code. 0 none, 1 CRC, 2 CMD8 echo mismatch, 3 ACMD41 timeout.
- `orca` output 16: card RCA.
- `ohcs` output 1: card is SDHC/SDXC (OCR CCS bit).

## Operation
- Every command state has two phases: ISSUE, then WAIT.
  - ISSUE: drive `ocmd_index`/`ocmd_arg` and pulse `ocmd_send` for one cycle.
  - WAIT: hold the index and argument stable until `icmd_done`.
- States and arguments:
  - IDLE
  - CMD0: arg 0, no response.
  - CMD8: arg 0x000001AA.
  - CMD55: arg {`orca`,16'h0}. RCA is 0 before CMD3.
  - ACMD41: arg 0x40FF8000.
  - CMD2: arg 0.
  - CMD3: arg 0.
  - CMD7: arg {`orca`,16'h0}.
  - READY
  - ERROR
- Response layout for 48-bit responses: `iresp[0]` start bit, `[2:7]` index, `[8:39]` payload, `[40:46]` CRC, `[47]` end bit.
- CMD8: `iresp[28:39]` must equal 12'h1AA, otherwise go to ERROR with code 2. V1.x cards are unsupported.
- ACMD41 (R3):
  - `icrc_failed` is ignored.
  - `iresp[8]`=1 means power-up done: capture `ohcs`←`iresp[9]` and go to CMD2.
  - `iresp[8]`=0: increment the round counter and return to CMD55.
  - After `ACMD41_TRIES` rounds without completion, go to ERROR with code 3.
- CMD3 (R6): `orca`←`iresp[8:23]`.
- CMD7 completion leads to READY, or to the CMD55W/ACMD6 extension when `SD_WIDE_BUS_EN` is defined.
- CRC failure on any CMD except ACMD41 and CMD0: re-issue the same command. The retry counter resets on every successful command. The failure after `CRC_RETRIES` retries goes to ERROR with code 1.
- `istart` is honored in IDLE, READY and ERROR. It clears `oready`, `oerr`, `oerr_code`, `orca`, `ohcs` and all counters, then enters CMD0. It is ignored in all other states.
- `icmd_done` arriving outside a WAIT phase is ignored.

## Timing
- Reset values: state IDLE; all outputs 0; counters 0.
- `irst` asserted mid-operation clears everything asynchronously, including an in-flight `ocmd_send`.
- Cycle after `istart` in IDLE: `ocmd_send`=1 with index 0 (ISSUE of CMD0).
- `icmd_done` at cycle N: the next ISSUE pulse occurs at N+1, and outputs for the new state update at N+1.
- `oready` and `oerr` are level outputs. They assert in the cycle after the final `icmd_done` and hold until `istart` or `irst`.
- `ocmd_send` is never asserted on two consecutive cycles.

## Configuration
- `SD_WIDE_BUS_EN` defined: after CMD7, issue CMD55 (arg {`orca`,16'h0}) then ACMD6 (index 6, arg 0x00000002) to select the 4-bit bus, then go to READY. CRC retry rules apply to both commands.
- `SD_WIDE_BUS_EN` undefined: CMD7 goes directly to READY and the bus stays 1-bit.

## Test plan
- Nominal SDHC card: ACMD41 returns `iresp[8:9]`=2'b11 on the 3rd round, R6 RCA=0xB368 → ordered commands 0,8,55,41 (×3 pairs),2,3,7. CMD7 arg 0xB3680000. `oready`=1, `ohcs`=1, `orca`=0xB368.
- CMD8 echo 0x0AA → `oerr`=1, code 2; no further `ocmd_send`.
- ACMD41 never completes with `ACMD41_TRIES`=4 → exactly 4 CMD55/ACMD41 pairs, then `oerr`=1, code 3.
- `icrc_failed` on CMD2 twice, then clean → CMD2 issued 3 times, then the sequence completes. With 4 consecutive failures → code 1 after the 4th CMD2.
- `irst` pulse during the CMD3 WAIT phase → all outputs 0 immediately; a following `istart` restarts at CMD0.
- `SD_WIDE_BUS_EN` defined → after CMD7, commands 55 (arg {RCA,0}) and 6 (arg 2) are issued before `oready`.
